div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage.
//   Answers the hazard unit's divide-stall input: div_stall freezes F/D/E
//   while the divide runs. The result goes to the HI/LO write path.
//   An exception flush from M aborts it.
// PARAMETERS
//   WIDTH  32  operand/quotient/remainder width in bits
// PORTS
//   clk         in   1      clock; all state updates on rising edge
//   resetn      in   1      synchronous reset, active-low
//   start       in   1      DIV/DIVU valid in E stage
//   signed_div  in   1      1 = DIV (signed), 0 = DIVU
//   a           in   WIDTH  dividend (rs), held stable by stall
//   b           in   WIDTH  divisor (rt), held stable by stall
//   flush       in   1      exception flush (exceptionM); abort
//   div_stall   out  1      stall request to hazard unit
//   ready       out  1      one-cycle pulse: quo/rem valid, write HI/LO
//   quo         out  WIDTH  quotient (to LO)
//   rem         out  WIDTH  remainder (to HI)
// BEHAVIOUR
//   Reset (resetn=0 at an edge): state=IDLE, cnt=0, ready=0, quo=0, rem=0.
//   Reset mid-operation gives the same result: abort, no ready.
//   States: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: start=1 & flush=0 latches |a|, |b|, sign_q=a[MSB]^b[MSB],
//     sign_r=a[MSB]. Sign terms apply only if signed_div, else 0.
//     Also cnt=0, go BUSY.
//   - BUSY: one quotient bit per cycle; partial remainder is WIDTH+1 bits.
//     Subtract |b|; keep the difference if it is non-negative, else restore.
//     cnt wraps WIDTH-1 -> 0 with move to DONE (WIDTH cycles in BUSY).
//   - DONE: ready=1 for exactly one cycle, then IDLE.
//     start is ignored in DONE (same instruction is leaving E).
//   div_stall = (IDLE & start & ~flush) | BUSY. It is combinational so
//   the pipeline freezes in the start cycle. It is 0 in DONE, so E
//   advances while ready is high.
//   Latency: start sampled at edge N -> ready high during cycle N+WIDTH+1.
//   Sign fix-up at entry to DONE:
//   - quo = sign_q ? -q : q
//   - rem = sign_r ? -r : r
//   - signed 0x80000000 / -1 -> quo=0x80000000, rem=0 (two's-complement wrap).
//   Divide by zero (b==0, either mode): quo={WIDTH{1}}, rem=a. No trap.
//   quo/rem hold their value until the next DONE. ready=0 outside DONE.
//   flush=1 at any edge: go IDLE, cnt=0, no ready pulse, quo/rem unchanged.
//   flush overrides start in the same cycle.
// CONFIGURATION
//   DIV_EARLY_OUT_EN defined:
//   - In IDLE, if b!=0 and |a|<|b|, go straight to DONE.
//   - Result: quo=0, rem=a.
//   - ready is high during cycle N+1 after start; div_stall high only in
//     the start cycle.
//   Not defined: every divide takes the full WIDTH BUSY cycles.
//   Results are identical with and without the macro.
// TESTING
//   1. DIVU 100/7: start at edge 0 -> div_stall=1 cycles 0..32,
//      ready cycle 33, quo=14, rem=2.
//   2. DIV -7/2 (0xFFFFFFF9/2): quo=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
//      Also 0x80000000/0xFFFFFFFF: quo=0x80000000, rem=0.
//   3. DIVU 5/0 and DIV -5/0: quo=0xFFFFFFFF, rem=a. Ready on cycle 33.
//   4. flush=1 at cycle 10 of BUSY: div_stall=0 from cycle 11, no ready
//      pulse, quo/rem keep previous values. A new start at cycle 12 gives
//      the correct result at cycle 45.
//   5. resetn=0 at cycle 5 of BUSY: all outputs 0 next cycle, state IDLE.
//      start held high across DONE does not retrigger.
//   6. DIVU 3/10 with DIV_EARLY_OUT_EN: ready cycle 1, quo=0, rem=3.
//      Without the macro: ready cycle 33, same values.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU with a stall request and a flush abort.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when b != 0 and |a| < |b|.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             div_stall,
   output logic             ready,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] remPart;
   logic             signQ;
   logic             signR;
   logic             divZero;

   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] nextQuo;
   logic [WIDTH-1:0] nextRem;
   logic [WIDTH-1:0] fixQuo;
   logic [WIDTH-1:0] fixRem;
   logic             earlyOut;

   always_comb begin
      absA = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
      absB = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;
   end

   // The partial remainder is always below the divisor, so it is stored in WIDTH bits;
   // only the shifted trial value needs the extra bit. A set MSB on the difference means restore.
   always_comb begin
      shifted = {remPart, quotient[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      nextQuo = {quotient[WIDTH-2:0], ~diff[WIDTH]};
      nextRem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   end

   // Divide by zero leaves the dividend magnitude in the remainder, so only the quotient is forced.
   always_comb begin
      fixQuo = divZero ? {WIDTH{1'b1}} : (signQ ? -nextQuo : nextQuo);
      fixRem = signR ? -nextRem : nextRem;
   end

`ifdef DIV_EARLY_OUT_EN
   assign earlyOut = (b != '0) && (absA < absB);
`else
   assign earlyOut = 1'b0;
`endif

   assign div_stall = ((state == IDLE) && start && !flush) || (state == BUSY);
   assign ready     = (state == DONE);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= '0;
         quotient <= '0;
         divisor  <= '0;
         remPart  <= '0;
         signQ    <= 1'b0;
         signR    <= 1'b0;
         divZero  <= 1'b0;
         quo      <= '0;
         rem      <= '0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  divisor  <= absB;
                  quotient <= absA;
                  remPart  <= '0;
                  signQ    <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                  signR    <= signed_div & a[WIDTH-1];
                  divZero  <= (b == '0);
                  cnt      <= '0;
                  if (earlyOut) begin
                     quo   <= '0;
                     rem   <= a;
                     state <= DONE;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               quotient <= nextQuo;
               remPart  <= nextRem;
               if (cnt == LAST) begin
                  cnt   <= '0;
                  quo   <= fixQuo;
                  rem   <= fixRem;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit covering signed/unsigned results, divide by zero,
// flush and reset aborts, and the latency with or without DIV_EARLY_OUT_EN.
module tb_div_unit;

   localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 33;
`endif

   logic         clk = 1'b0;
   logic         resetn;
   logic         start;
   logic         signed_div;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         flush;
   logic         div_stall;
   logic         ready;
   logic [W-1:0] quo;
   logic [W-1:0] rem;

   int testCount = 0;
   int failCount = 0;

   div_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .signed_div (signed_div),
      .a          (a),
      .b          (b),
      .flush      (flush),
      .div_stall  (div_stall),
      .ready      (ready),
      .quo        (quo),
      .rem        (rem)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Start in cycle 0, hold start until past the DONE edge, then confirm no retrigger.
   task automatic applyStimulus(input string tag, input logic sgn, input logic [W-1:0] av,
                                input logic [W-1:0] bv, input logic [W-1:0] expQuo,
                                input logic [W-1:0] expRem, input int expLat);
      int cycles;
      int stallBad;
      cycles   = 0;
      stallBad = 0;
      @(negedge clk);
      signed_div = sgn;
      a          = av;
      b          = bv;
      start      = 1'b1;
      #1;
      checkOutput({tag, " stall start"}, W'(div_stall), W'(1));
      while (cycles < 60) begin
         @(negedge clk);
         #1;
         cycles++;
         if (ready) break;
         if (!div_stall) stallBad++;
      end
      checkOutput({tag, " ready seen"}, W'(ready), W'(1));
      checkOutput({tag, " latency"}, W'(cycles), W'(expLat));
      checkOutput({tag, " stall busy"}, W'(stallBad), W'(0));
      checkOutput({tag, " stall done"}, W'(div_stall), W'(0));
      checkOutput({tag, " quo"}, quo, expQuo);
      checkOutput({tag, " rem"}, rem, expRem);
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput({tag, " idle stall"}, W'(div_stall), W'(0));
      checkOutput({tag, " idle ready"}, W'(ready), W'(0));
      checkOutput({tag, " hold quo"}, quo, expQuo);
   endtask

   initial begin
      resetn     = 1'b0;
      start      = 1'b0;
      signed_div = 1'b0;
      a          = '0;
      b          = '0;
      flush      = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset stall", W'(div_stall), W'(0));
      checkOutput("reset ready", W'(ready), W'(0));
      checkOutput("reset quo", quo, '0);
      checkOutput("reset rem", rem, '0);
      resetn = 1'b1;

      applyStimulus("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
      applyStimulus("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
      applyStimulus("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
      applyStimulus("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
      applyStimulus("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
      applyStimulus("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 33);
      applyStimulus("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 33);

      // Flush in BUSY cycle 10; previous results must survive
      @(negedge clk);
      signed_div = 1'b0;
      a          = 32'd1000;
      b          = 32'd3;
      start      = 1'b1;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      start = 1'b0;
      #1;
      checkOutput("flush busy stall", W'(div_stall), W'(1));
      @(negedge clk);
      flush = 1'b0;
      #1;
      checkOutput("flush after stall", W'(div_stall), W'(0));
      checkOutput("flush after ready", W'(ready), W'(0));
      checkOutput("flush keep quo", quo, 32'hFFFF_FFFF);
      checkOutput("flush keep rem", rem, 32'hFFFF_FFFB);
      applyStimulus("divu 1000/3 restart", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

      // Flush overrides start in IDLE
      @(negedge clk);
      a     = 32'd50;
      b     = 32'd5;
      start = 1'b1;
      flush = 1'b1;
      #1;
      checkOutput("flush vs start stall", W'(div_stall), W'(0));
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      checkOutput("flush vs start idle", W'(div_stall), W'(0));
      checkOutput("flush vs start ready", W'(ready), W'(0));

      // Reset in BUSY cycle 5 clears everything
      @(negedge clk);
      a     = 32'd77;
      b     = 32'd4;
      start = 1'b1;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      start  = 1'b0;
      #1;
      checkOutput("midreset stall", W'(div_stall), W'(0));
      checkOutput("midreset ready", W'(ready), W'(0));
      checkOutput("midreset quo", quo, '0);
      checkOutput("midreset rem", rem, '0);

      applyStimulus("divu 3/10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, EARLY_LAT);
      applyStimulus("div -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, EARLY_LAT);
      applyStimulus("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, EARLY_LAT);
      applyStimulus("divu 9/9", 1'b0, 32'd9, 32'd9, 32'd1, 32'd0, 33);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
